// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: controller
// state encoding and operation codes.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit_cell.sv
// One-bit full-adder cell built from gate primitives; the only arithmetic
// hardware in the serial engine, reused once per bit position.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    wire ab_xor;
    wire ab_and;
    wire prop_and;

    xor g_xor0 (ab_xor, a, b);
    xor g_xor1 (sum, ab_xor, cin);
    and g_and0 (ab_and, a, b);
    and g_and1 (prop_and, ab_xor, cin);
    or  g_or0  (cout, ab_and, prop_and);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: captures operands on an accepted start,
// feeds them LSB first through one full-adder cell with a registered carry,
// and presents sum/cout/ovf with a one-cycle done pulse after WIDTH cycles.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int              CW       = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;
    logic             accept;
    logic             last_bit;

    assign accept   = ready & start;
    assign last_bit = (cnt == CNT_LAST);
    // New bit enters at the MSB; written as a shift of the concatenation so
    // that WIDTH=1 needs no special case.
    assign sum_next = WIDTH'({fa_sum, sum} >> 1);

    fa_bit_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register with synchronous reset; a reset mid-RUN simply aborts.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode: run for WIDTH cycles, then a single DONE cycle.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start)    state_nx = ST_RUN;
            ST_RUN:  if (last_bit) state_nx = ST_DONE;
            ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so busy and ready never overlap.
    always_comb begin
        ready = (state == ST_IDLE) || (state == ST_DONE);
        busy  = (state == ST_RUN);
        done  = (state == ST_DONE);
    end

    // Operand shift registers: loaded on accept, shifted right each RUN cycle.
    always_ff @(posedge clk) begin
        // NOTE: operand shifters carry no reset; they are always reloaded before use.
        if (accept) begin
            a_sh <= a;
            b_sh <= (op_sub == OP_SUB) ? ~b : b;
        end else if (busy) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
        end
    end

    // Counter, carry flop and result registers; result holds until the first
    // bit of the next operation shifts in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= (op_sub == OP_ADD) ? cin : 1'b1;
        end else if (busy) begin
            sum   <= sum_next;
            carry <= fa_cout;
            if (last_bit) begin
                cout <= fa_cout;
                ovf  <= carry ^ fa_cout;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule
